tile_loader: RTL

TILE_LOADER -- requirements
Module: tile_loader

---
 rtl/tile_loader.sv | 116 +++++++++++
 1 files changed

// File: rtl/tile_loader.sv
// tile_loader: collects 16-word rows into a lane x 16 tile, saturating each word to IL+FL bits,
// then holds the finished tile until the downstream stage acknowledges it.
`default_nettype none

module tile_loader #(
   parameter int IL    = 8,
   parameter int FL    = 12,
   parameter int lane  = 128,
   parameter int GUARD = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             mode,
   input  logic                             start,
   input  logic                             beat_valid,
   output logic                             beat_ready,
   input  logic signed [IL+FL+GUARD-1:0]    beat_data [16],
   output logic signed [IL+FL-1:0]          tile_out  [lane][16],
   output logic                             mode_out,
   output logic                             tile_valid,
   input  logic                             tile_ack,
   output logic                             busy
);

   localparam int OW = IL + FL;
   localparam int IW = OW + GUARD;
   localparam int CW = (lane > 1) ? $clog2(lane) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   row_cnt;
   logic [CW-1:0]   last_row;
   logic            accept;
   logic            last_beat;
   logic            load;

   // The guard bits plus the output sign bit must all agree for the word to fit.
   function automatic logic signed [OW-1:0] saturate(input logic signed [IW-1:0] x);
      logic [GUARD:0] top;
      top = x[IW-1:OW-1];
      if (top == '0 || top == '1)
         return x[OW-1:0];
      else if (x[IW-1])
         return {1'b1, {(OW-1){1'b0}}};
      else
         return {1'b0, {(OW-1){1'b1}}};
   endfunction

   assign load      = (state == IDLE) && start;
   assign accept    = (state == FILL) && beat_valid;
   assign last_row  = mode_out ? CW'(lane - 1) : '0;
   assign last_beat = (row_cnt == last_row);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      beat_ready = 1'b0;
      tile_valid = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start)
               state_nxt = FILL;
         end
         FILL: begin
            beat_ready = 1'b1;
            if (accept && last_beat)
               state_nxt = HOLD;
         end
         HOLD: begin
            tile_valid = 1'b1;
            if (tile_ack)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_out <= 1'b0;
         row_cnt  <= '0;
         for (int r = 0; r < lane; r++)
            for (int k = 0; k < 16; k++)
               tile_out[r][k] <= '0;
      end else if (load) begin
         mode_out <= mode;
         row_cnt  <= '0;
         for (int r = 0; r < lane; r++)
            for (int k = 0; k < 16; k++)
               tile_out[r][k] <= '0;
      end else if (accept) begin
         for (int k = 0; k < 16; k++)
            tile_out[row_cnt][k] <= saturate(beat_data[k]);
         // Counter parks on the last row so it never leaves 0..lane-1.
         if (!last_beat)
            row_cnt <= row_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire
